count_uart_tx: RTL and testbench
================================

Name: count_uart_tx

Overview:
- Downstream consumer of the 8-bit counter value driven onto uo_out by the top wrapper.
- Serialises the count as standard 8N1 UART frames on one output pin, so the counter can be read from a host terminal.
- Frames are sent on request, or automatically whenever the count differs from the last value sent.
- Sits in the top wrapper beside the counter; its tx drives one uio_out bit with the matching uio_oe bit set.

Parameters:
- CLKS_PER_BIT, 87, clock cycles per UART bit (10 MHz / 115200 baud). Legal range 2..65535.

Ports:
- clk  input  1  system clock, rising-edge
- rst_n  input  1  reset, asynchronous, active-low
- count_in  input  8  counter value to transmit
- send_on_change  input  1  1 = auto-trigger a frame when count_in != last_sent
- start  input  1  single-cycle request to send the current count_in
- tx  output  1  UART serial line; idle high
- busy  output  1  high while a frame is in progress
- drop  output  1  one-cycle pulse when a start request is discarded

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: tx=1, busy=0, drop=0, state=IDLE, last_sent=8'h00, pending=0, bit and baud counters=0.
- Reset asserted mid-frame: tx returns to 1 immediately (asynchronously) and the frame is abandoned. No resume after reset release.
- FSM states: IDLE, START, DATA, STOP.
- Trigger condition in IDLE, evaluated each rising edge: start=1, OR pending=1, OR (send_on_change=1 AND count_in != last_sent).
- On a trigger at edge T:
  - count_in is captured into the shift register and into last_sent.
  - state moves to START, and pending is cleared.
  - tx=0 and busy=1 are visible after edge T.
- START: tx=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA: 8 bits, LSB first, each held for CLKS_PER_BIT cycles. Bit index counts 0..7, then go to STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles, then go to IDLE with busy=0.
- Frame length: exactly 10*CLKS_PER_BIT cycles from the edge tx falls to the edge busy falls.
- After returning to IDLE, the FSM spends at least one cycle in IDLE before the next trigger. This guarantees at least 1 extra stop-level cycle between back-to-back frames.
- Baud counter counts 0..CLKS_PER_BIT-1 and wraps. A bit boundary occurs at the wrap. Counter width is $clog2(CLKS_PER_BIT).
- Data is frozen once captured: count_in changes during a frame do not alter the frame in flight.
- Auto-trigger while busy:
  - Not queued explicitly.
  - On return to IDLE, the comparison against last_sent naturally sends the newest value once.
  - Intermediate values are skipped by design.
- start=1 while busy and pending=0: pending is set. The pending frame transmits count_in as sampled at its own trigger edge, not at request time.
- start=1 while busy and pending=1: the request is discarded and drop pulses high for exactly one cycle.
- start=1 in IDLE on the same edge as an auto-trigger: a single frame is sent, and pending is not set.
- start=1 on the same edge busy falls (last STOP cycle): the request is treated as busy, so pending is set and the next frame follows after the mandatory IDLE cycle.
- send_on_change=0: only start or pending trigger a frame. last_sent is still updated on every frame.
- Any value of count_in is legal (0x00..0xFF). No parity bit is added.

Test Plan (CLKS_PER_BIT=4):
- Reset: rst_n=0 -> tx=1, busy=0, drop=0. Release with count_in=0x00, send_on_change=1 -> no frame for 100 cycles.
- Manual send: start pulse with count_in=0xA5 -> tx sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles. busy high for exactly 40 cycles.
- Auto-send: send_on_change=1, count_in changes 0x00->0x01 -> frame carrying 0x01 begins the next cycle. Holding 0x01 produces no further frames.
- Changes during a frame: count_in steps 0x01..0x05 while a frame is busy -> the frame in flight is unchanged. Exactly one follow-up frame carries 0x05, starting 1 cycle after busy falls.
- Queued start: during a frame, start pulses twice 8 cycles apart -> the first request is queued (one extra frame), the second gives drop=1 for one cycle. Total frames = 2.
- Mid-frame reset: rst_n=0 at cycle 13 of a frame -> tx=1 and busy=0 immediately. After release, last_sent=0x00, so a non-zero count_in with send_on_change=1 re-sends.

Source files
------------

// File: rtl/count_uart_tx_if.sv
// rtl/count_uart_tx_if.sv - stream-side signals of the counter UART transmitter
// The master drives the count and requests; the slave (transmitter) drives the line and status.
interface count_uart_tx_if;
   logic [7:0] count_in;
   logic       send_on_change;
   logic       start;
   logic       tx;
   logic       busy;
   logic       drop;

   modport master (
      output count_in,
      output send_on_change,
      output start,
      input  tx,
      input  busy,
      input  drop
   );

   modport slave (
      input  count_in,
      input  send_on_change,
      input  start,
      output tx,
      output busy,
      output drop
   );
endinterface

// File: rtl/count_uart_tx.sv
// rtl/count_uart_tx.sv - 8N1 UART transmitter for the counter value
// Frames go out on start, on a queued request, or when the count moves away from the last value sent.
module count_uart_tx #(
   parameter int CLKS_PER_BIT = 87
) (
   input  logic           clk,
   input  logic           rst_n,
   count_uart_tx_if.slave bus
);
   localparam int            CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] baud_q, baud_d;
   logic [2:0]    bit_idx_q, bit_idx_d;
   logic [7:0]    shift_q, shift_d;
   logic [7:0]    last_sent_q, last_sent_d;
   logic          pending_q, pending_d;
   logic          tx_q, tx_d;
   logic          drop_q, drop_d;
   logic          busy;
   logic          baud_wrap;
   logic          trigger;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         baud_q      <= '0;
         bit_idx_q   <= '0;
         shift_q     <= '0;
         last_sent_q <= '0;
         pending_q   <= 1'b0;
         tx_q        <= 1'b1;
         drop_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         baud_q      <= baud_d;
         bit_idx_q   <= bit_idx_d;
         shift_q     <= shift_d;
         last_sent_q <= last_sent_d;
         pending_q   <= pending_d;
         tx_q        <= tx_d;
         drop_q      <= drop_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      baud_d      = baud_q;
      bit_idx_d   = bit_idx_q;
      shift_d     = shift_q;
      last_sent_d = last_sent_q;
      pending_d   = pending_q;
      tx_d        = tx_q;
      drop_d      = 1'b0;

      busy      = (state_q != S_IDLE);
      baud_wrap = (baud_q == BAUD_LAST);
      trigger   = bus.start | pending_q |
                  (bus.send_on_change & (bus.count_in != last_sent_q));

      // A request during a frame (including its last STOP cycle) is queued once; a second is dropped.
      if (busy && bus.start) begin
         if (pending_q) begin
            drop_d = 1'b1;
         end else begin
            pending_d = 1'b1;
         end
      end

      case (state_q)
         S_IDLE: begin
            tx_d      = 1'b1;
            baud_d    = '0;
            bit_idx_d = '0;
            if (trigger) begin
               shift_d     = bus.count_in;
               last_sent_d = bus.count_in;
               pending_d   = 1'b0;
               tx_d        = 1'b0;
               state_d     = S_START;
            end
         end

         S_START: begin
            if (baud_wrap) begin
               baud_d  = '0;
               tx_d    = shift_q[0];
               state_d = S_DATA;
            end else begin
               baud_d = baud_q + CW'(1);
            end
         end

         S_DATA: begin
            if (baud_wrap) begin
               baud_d = '0;
               if (bit_idx_q == 3'd7) begin
                  tx_d    = 1'b1;
                  state_d = S_STOP;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
                  shift_d   = {1'b0, shift_q[7:1]};
                  tx_d      = shift_q[1];
               end
            end else begin
               baud_d = baud_q + CW'(1);
            end
         end

         S_STOP: begin
            tx_d = 1'b1;
            if (baud_wrap) begin
               baud_d  = '0;
               state_d = S_IDLE;
            end else begin
               baud_d = baud_q + CW'(1);
            end
         end

         default: begin
            tx_d    = 1'b1;
            baud_d  = '0;
            state_d = S_IDLE;
         end
      endcase
   end

   assign bus.tx   = tx_q;
   assign bus.busy = busy;
   assign bus.drop = drop_q;
endmodule

// File: tb/tb_count_uart_tx.sv
// tb/tb_count_uart_tx.sv - directed bench for count_uart_tx at 4 clocks per bit
module tb_count_uart_tx;
   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   count_uart_tx_if bus ();

   count_uart_tx #(.CLKS_PER_BIT(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Entered one step after the trigger edge; leaves one step after the edge busy must fall.
   task automatic run_frame(input string tag, input logic [7:0] exp_data);
      logic [9:0] bits;
      int         busy_n;
      int         glitches;
      bits     = '0;
      busy_n   = 0;
      glitches = 0;
      for (int c = 0; c < 40; c++) begin
         if (c % 4 == 0) bits[c / 4] = bus.tx;
         else if (bus.tx !== bits[c / 4]) glitches++;
         if (bus.busy === 1'b1) busy_n++;
         tick();
      end
      check_eq({tag, "_bits"}, 32'(bits), 32'({1'b1, exp_data, 1'b0}));
      check_eq({tag, "_glitch"}, glitches, 0);
      check_eq({tag, "_busy_len"}, busy_n, 40);
      check_eq({tag, "_busy_fall"}, 32'(bus.busy), 0);
   endtask

   task automatic idle_check(input string tag, input int n);
      int seen;
      seen = 0;
      repeat (n) begin
         if (bus.busy !== 1'b0 || bus.tx !== 1'b1) seen++;
         tick();
      end
      check_eq(tag, seen, 0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      total              = 0;
      bad                = 0;
      rst_n              = 1'b0;
      bus.start          = 1'b0;
      bus.count_in       = 8'h00;
      bus.send_on_change = 1'b1;

      // Reset values, then a quiet line with count equal to the reset last_sent.
      repeat (3) tick();
      check_eq("rst_tx", 32'(bus.tx), 1);
      check_eq("rst_busy", 32'(bus.busy), 0);
      check_eq("rst_drop", 32'(bus.drop), 0);
      rst_n = 1'b1;
      idle_check("rst_quiet", 100);

      // Manual send with auto-trigger off.
      bus.send_on_change = 1'b0;
      bus.count_in       = 8'hA5;
      idle_check("soc_off_quiet", 10);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      check_eq("man_busy_rise", 32'(bus.busy), 1);
      run_frame("man_a5", 8'hA5);

      // Auto-send after a fresh reset.
      bus.count_in       = 8'h00;
      bus.send_on_change = 1'b1;
      do_reset();
      repeat (5) tick();
      bus.count_in = 8'h01;
      tick();
      check_eq("auto_busy", 32'(bus.busy), 1);
      check_eq("auto_tx", 32'(bus.tx), 0);
      run_frame("auto_01", 8'h01);
      idle_check("auto_hold", 60);

      // Count moves during a frame: frame frozen, one follow-up with newest value.
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      fork
         run_frame("chg_01", 8'h01);
         begin
            for (int v = 2; v <= 5; v++) begin
               repeat (5) tick();
               bus.count_in = 8'(v);
            end
         end
      join
      tick();
      check_eq("chg_follow_busy", 32'(bus.busy), 1);
      run_frame("chg_05", 8'h05);
      idle_check("chg_quiet", 60);

      // Two starts during a frame: first queued, second dropped.
      bus.send_on_change = 1'b0;
      bus.count_in       = 8'h3C;
      bus.start          = 1'b1;
      tick();
      bus.start = 1'b0;
      fork
         run_frame("q_3c", 8'h3C);
         begin
            repeat (5) tick();
            bus.start = 1'b1;
            tick();
            bus.start = 1'b0;
            check_eq("q_first_nodrop", 32'(bus.drop), 0);
            repeat (7) tick();
            bus.start = 1'b1;
            tick();
            bus.start = 1'b0;
            check_eq("q_drop_pulse", 32'(bus.drop), 1);
            tick();
            check_eq("q_drop_end", 32'(bus.drop), 0);
            repeat (5) tick();
            bus.count_in = 8'h77;
         end
      join
      tick();
      check_eq("q_pend_busy", 32'(bus.busy), 1);
      run_frame("q_77", 8'h77);
      idle_check("q_quiet", 60);

      // Reset in the middle of a frame, then resend because last_sent is cleared.
      bus.count_in       = 8'h5A;
      bus.send_on_change = 1'b1;
      tick();
      check_eq("mr_busy", 32'(bus.busy), 1);
      repeat (12) tick();
      check_eq("mr_tx_pre", 32'(bus.tx), 0);
      rst_n = 1'b0;
      #1;
      check_eq("mr_tx_async", 32'(bus.tx), 1);
      check_eq("mr_busy_async", 32'(bus.busy), 0);
      repeat (3) tick();
      rst_n = 1'b1;
      tick();
      check_eq("mr_resend_busy", 32'(bus.busy), 1);
      run_frame("mr_5a", 8'h5A);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
